// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
//   Clocked interrupt-acknowledge sequencer for an 8259A-style PIC in 8086 mode.
//   It raises the CPU interrupt, follows the two INTA pulses, freezes the IRR
//   snapshot, and commands ISR set and AEOI clear. It returns the vector byte
//   (master/single, or a selected slave) or the cascade address (a master with
//   a slave on the winning input). An overlong gap between INTA pulses aborts
//   the cycle.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-high reset
//   int_request       priority resolver has an unmasked winner
//   int_index [2:0]   index of that winner
//   inta_n            CPU acknowledge, active-low, already synchronous to clk
//   icw_done          initialization complete; gates new requests
//   vector_base [4:0] ICW2[7:3]
//   aeoi, single, sp  ICW4 AEOI, ICW1 SNGL, master(1)/slave(0)
//   icw3 [7:0]        master: slave-present mask; slave: [2:0] = own ID
//   cas_in [2:0]      cascade lines as seen by a slave
//   intr              interrupt to CPU ("int" is a reserved word in SV)
//   freeze            hold IRR/priority snapshot
//   isr_set           one-cycle pulse: set ISR bit isr_index
//   isr_index [2:0]   index latched at the first INTA
//   isr_clear         one-cycle pulse: AEOI clear of isr_index
//   data_out [7:0]    vector byte; data_oe drives it onto the bus
//   cas_out [2:0]     cascade address; cas_oe drives it
//   timeout_abort     one-cycle pulse when the second INTA never arrives
//   All outputs are registered.
module pic_inta_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_request,
  input  logic [2:0] int_index,
  input  logic       inta_n,
  input  logic       icw_done,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       single,
  input  logic       sp,
  input  logic [7:0] icw3,
  input  logic [2:0] cas_in,
  output logic       intr,
  output logic       freeze,
  output logic       isr_set,
  output logic [2:0] isr_index,
  output logic       isr_clear,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       timeout_abort
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT_ACK2, ACK2} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_d;
  logic             inta_n_q;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             intr_d, freeze_d, isr_set_d, isr_clear_d;
  logic             data_oe_d, cas_oe_d, timeout_abort_d;
  logic [2:0]       isr_index_d, cas_out_d;
  logic [7:0]       data_out_d;
  // set_done: an ISR set was commanded in this sequence (gates AEOI clear).
  // spur: the request vanished while in REQ; the acknowledge becomes IR7.
  logic             set_done, set_done_d;
  logic             spur, spur_d;

  logic       fall, rise;
  logic       spurious_now;
  logic [2:0] ack_index;

  assign fall         = inta_n_q & ~inta_n;
  assign rise         = ~inta_n_q & inta_n;
  assign spurious_now = spur | ~int_request;
  assign ack_index    = spurious_now ? 3'd7 : int_index;

  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    intr_d          = intr;
    freeze_d        = freeze;
    isr_set_d       = 1'b0;
    isr_index_d     = isr_index;
    isr_clear_d     = 1'b0;
    data_out_d      = data_out;
    data_oe_d       = data_oe;
    cas_out_d       = cas_out;
    cas_oe_d        = cas_oe;
    timeout_abort_d = 1'b0;
    set_done_d      = set_done;
    spur_d          = spur;

    unique case (state)
      IDLE: begin
        // INTA edges are not looked at here, so a fall coinciding with the
        // request is ignored and REQ always gets one settled cycle.
        if (icw_done && int_request) begin
          state_d    = REQ;
          intr_d     = 1'b1;
          set_done_d = 1'b0;
          spur_d     = 1'b0;
        end
      end
      REQ: begin
        if (fall) begin
          state_d     = ACK1;
          intr_d      = 1'b0;
          freeze_d    = 1'b1;
          isr_index_d = ack_index;
          spur_d      = spurious_now;
          // Slaves defer ISR set until their cascade address is confirmed.
          if ((single || sp) && !spurious_now) begin
            isr_set_d  = 1'b1;
            set_done_d = 1'b1;
          end
          cas_out_d = ack_index;
          cas_oe_d  = !single && sp && icw3[ack_index];
        end else if (!int_request) begin
          spur_d = 1'b1;
        end
      end
      ACK1: begin
        if (rise) begin
          state_d = WAIT_ACK2;
          cnt_d   = '0;
        end
      end
      WAIT_ACK2: begin
        if (cnt != '1) cnt_d = cnt + CNT_W'(1);
        if (fall) begin
          state_d = ACK2;
          if (single || (sp && !icw3[isr_index])) begin
            data_out_d = {vector_base, isr_index};
            data_oe_d  = 1'b1;
          end else if (!sp && cas_in == icw3[2:0]) begin
            data_out_d = {vector_base, isr_index};
            data_oe_d  = 1'b1;
            if (!spur) begin
              isr_set_d  = 1'b1;
              set_done_d = 1'b1;
            end
          end
        end else if (cnt == LAST) begin
          state_d         = IDLE;
          timeout_abort_d = 1'b1;
          freeze_d        = 1'b0;
          cas_oe_d        = 1'b0;
          cas_out_d       = '0;
        end
      end
      ACK2: begin
        if (rise) begin
          state_d     = IDLE;
          data_oe_d   = 1'b0;
          data_out_d  = '0;
          cas_oe_d    = 1'b0;
          cas_out_d   = '0;
          freeze_d    = 1'b0;
          isr_clear_d = aeoi && set_done;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      inta_n_q      <= 1'b1;
      cnt           <= '0;
      intr          <= 1'b0;
      freeze        <= 1'b0;
      isr_set       <= 1'b0;
      isr_index     <= '0;
      isr_clear     <= 1'b0;
      data_out      <= '0;
      data_oe       <= 1'b0;
      cas_out       <= '0;
      cas_oe        <= 1'b0;
      timeout_abort <= 1'b0;
      set_done      <= 1'b0;
      spur          <= 1'b0;
    end else begin
      state         <= state_d;
      inta_n_q      <= inta_n;
      cnt           <= cnt_d;
      intr          <= intr_d;
      freeze        <= freeze_d;
      isr_set       <= isr_set_d;
      isr_index     <= isr_index_d;
      isr_clear     <= isr_clear_d;
      data_out      <= data_out_d;
      data_oe       <= data_oe_d;
      cas_out       <= cas_out_d;
      cas_oe        <= cas_oe_d;
      timeout_abort <= timeout_abort_d;
      set_done      <= set_done_d;
      spur          <= spur_d;
    end
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Testbench for pic_inta_sequencer: directed scenarios plus randomized INTA
// sequences compared against a rule-level model of the acknowledge outcome.
module tb_pic_inta_sequencer;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       reset, int_request, inta_n, icw_done, aeoi, single, sp;
  logic [2:0] int_index, cas_in;
  logic [4:0] vector_base;
  logic [7:0] icw3;
  logic       intr, freeze, isr_set, isr_clear, data_oe, cas_oe, timeout_abort;
  logic [2:0] isr_index, cas_out;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;

  // Observations gathered while a sequence runs. win: 0 before first INTA,
  // 1 ACK1/WAIT_ACK2, 2 ACK2, 3 after the final rise.
  int         win, win_n, set_cnt, set_w, set_pos, clr_cnt, clr_pos, cas_hi, cas_lo, to_cnt;
  logic [2:0] set_idx, clr_idx, cas_val;
  logic       int_req_seen, int_after, oe_out, oe2, frz1, frz_end;
  logic [7:0] dout2;

  always #5 clk = ~clk;

  pic_inta_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .int_request(int_request), .int_index(int_index),
    .inta_n(inta_n), .icw_done(icw_done), .vector_base(vector_base), .aeoi(aeoi),
    .single(single), .sp(sp), .icw3(icw3), .cas_in(cas_in), .intr(intr),
    .freeze(freeze), .isr_set(isr_set), .isr_index(isr_index), .isr_clear(isr_clear),
    .data_out(data_out), .data_oe(data_oe), .cas_out(cas_out), .cas_oe(cas_oe),
    .timeout_abort(timeout_abort)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
    win_n++;
    if (isr_set) begin set_cnt++; set_idx = isr_index; set_w = win; set_pos = win_n; end
    if (isr_clear) begin clr_cnt++; clr_idx = isr_index; clr_pos = win_n; end
    if (timeout_abort) to_cnt++;
    if (win == 1 || win == 2) begin
      if (intr) int_after = 1'b1;
      if (cas_oe) begin cas_hi++; cas_val = cas_out; end else cas_lo++;
    end
    if (win != 2 && data_oe) oe_out = 1'b1;
    if (win == 1 && win_n == 1) frz1 = freeze;
    if (win == 2 && win_n == 1) begin oe2 = data_oe; dout2 = data_out; end
    if (win == 3 && win_n == 1) frz_end = freeze;
  endtask

  task automatic open_win(input int w);
    win = w; win_n = 0;
  endtask

  task automatic clear_capture();
    open_win(0);
    set_cnt = 0; set_w = 0; set_pos = 0; clr_cnt = 0; clr_pos = 0;
    cas_hi = 0; cas_lo = 0; to_cnt = 0;
    set_idx = '0; clr_idx = '0; cas_val = '0; dout2 = '0;
    int_req_seen = 0; int_after = 0; oe_out = 0; oe2 = 0; frz1 = 0; frz_end = 1;
  endtask

  // Bounded wait for INT after raising the request; an expiry counts as a failure.
  task automatic wait_int();
    int k = 0;
    do begin step(); k++; end while (intr !== 1'b1 && k < 8);
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL int_wait: int=%b, required 1 within 8 cycles", intr); end
  endtask

  // Full two-pulse acknowledge with randomized pulse widths and gap (gap < TO).
  task automatic run_seq(input logic s_i, p_i, a_i, input logic [7:0] i3_i,
                         input logic [2:0] cas_i, idx_i, input logic [4:0] vb_i, input logic drop);
    single = s_i; sp = p_i; aeoi = a_i; icw3 = i3_i; vector_base = vb_i;
    int_index = idx_i; cas_in = 3'($urandom); icw_done = 1'b1; inta_n = 1'b1;
    clear_capture();
    int_request = 1'b1;
    wait_int();
    step();
    int_req_seen = intr;
    if (drop) begin int_request = 1'b0; step(); end
    inta_n = 1'b0; open_win(1); step();
    int_index = 3'($urandom); cas_in = 3'($urandom);
    repeat ($urandom_range(0, 2)) step();
    inta_n = 1'b1; step();
    repeat ($urandom_range(0, 2)) step();
    inta_n = 1'b0; cas_in = cas_i; open_win(2); step();
    cas_in = 3'($urandom);
    repeat ($urandom_range(0, 2)) step();
    inta_n = 1'b1; int_request = 1'b0; open_win(3); step();
    repeat (3) step();
  endtask

  // Outcome of one acknowledge, derived from the configuration rules.
  function automatic void model(input logic s_i, p_i, a_i, input logic [7:0] i3_i,
                                input logic [2:0] cas_i, idx_i, input logic [4:0] vb_i, input logic drop,
                                output logic [2:0] e_idx, output logic e_casc, e_set,
                                output int e_set_w, output logic e_drive, output logic [7:0] e_vec,
                                output logic e_clr);
    logic slave, match;
    e_idx   = drop ? 3'd7 : idx_i;
    slave   = !s_i && !p_i;
    match   = slave && (cas_i == i3_i[2:0]);
    e_casc  = !s_i && p_i && i3_i[e_idx];
    e_set   = !drop && (!slave || match);
    e_set_w = slave ? 2 : 1;
    e_drive = s_i || (p_i && !e_casc) || match;
    e_vec   = {vb_i, e_idx};
    e_clr   = a_i && e_set;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1; int_request = 1'b0; inta_n = 1'b1;
    step(); reset = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; icw_done = 1'b1; int_request = 1'b1; int_index = 3'd5;
    inta_n = 1'b0; step(); inta_n = 1'b1; step(); inta_n = 1'b0; step();
    checks++;
    if ({intr, freeze, isr_set, isr_index, isr_clear, data_out, data_oe, cas_out, cas_oe, timeout_abort} !== 21'd0) begin
      errors++; $display("FAIL reset_outputs: int=%b freeze=%b data_oe=%b cas_oe=%b data_out=%h, required all 0",
                         intr, freeze, data_oe, cas_oe, data_out);
    end
    int_request = 1'b0; inta_n = 1'b1; step(); reset = 1'b0; step();
  endtask

  task automatic test_single_vector();
    run_seq(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'd3, 5'b01000, 1'b0);
    checks++; if (int_req_seen !== 1'b1) begin errors++; $display("FAIL single_int_req: got %b required 1", int_req_seen); end
    checks++; if (set_cnt !== 1 || set_idx !== 3'd3 || set_w !== 1 || set_pos !== 1) begin
      errors++; $display("FAIL single_isr_set: cnt=%0d idx=%0d win=%0d pos=%0d, required 1/3/1/1", set_cnt, set_idx, set_w, set_pos); end
    checks++; if (oe2 !== 1'b1 || dout2 !== 8'h43) begin
      errors++; $display("FAIL single_vector: oe=%b data=%h, required 1/43", oe2, dout2); end
    checks++; if (int_after !== 1'b0) begin errors++; $display("FAIL single_int_drop: got %b required 0", int_after); end
    checks++; if (clr_cnt !== 0) begin errors++; $display("FAIL single_no_clear: got %0d required 0", clr_cnt); end
  endtask

  task automatic test_aeoi();
    run_seq(1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 3'd3, 5'b01000, 1'b0);
    checks++; if (clr_cnt !== 1 || clr_idx !== 3'd3 || clr_pos !== 1) begin
      errors++; $display("FAIL aeoi_clear: cnt=%0d idx=%0d pos=%0d, required 1/3/1", clr_cnt, clr_idx, clr_pos); end
    checks++; if (frz1 !== 1'b1 || frz_end !== 1'b0) begin
      errors++; $display("FAIL aeoi_freeze: ack1=%b end=%b, required 1/0", frz1, frz_end); end
  endtask

  task automatic test_cascade_master();
    run_seq(1'b0, 1'b1, 1'b0, 8'h04, 3'd0, 3'd2, 5'b11110, 1'b0);
    checks++; if (cas_lo !== 0 || cas_val !== 3'd2) begin
      errors++; $display("FAIL casc_cas: low_samples=%0d cas_out=%0d, required 0/2", cas_lo, cas_val); end
    checks++; if (oe2 !== 1'b0 || oe_out !== 1'b0) begin
      errors++; $display("FAIL casc_no_data: oe_ack2=%b oe_other=%b, required 0/0", oe2, oe_out); end
    checks++; if (cas_oe !== 1'b0) begin errors++; $display("FAIL casc_cas_release: got %b required 0", cas_oe); end
    run_seq(1'b0, 1'b1, 1'b0, 8'h04, 3'd0, 3'd5, 5'b11110, 1'b0);
    checks++; if (oe2 !== 1'b1 || dout2 !== 8'hF5 || cas_hi !== 0) begin
      errors++; $display("FAIL casc_noslave: oe=%b data=%h cas_hi=%0d, required 1/f5/0", oe2, dout2, cas_hi); end
  endtask

  task automatic test_slave();
    run_seq(1'b0, 1'b0, 1'b1, 8'h06, 3'd6, 3'd4, 5'b10101, 1'b0);
    checks++; if (set_cnt !== 1 || set_w !== 2 || set_idx !== 3'd4) begin
      errors++; $display("FAIL slave_match_set: cnt=%0d win=%0d idx=%0d, required 1/2/4", set_cnt, set_w, set_idx); end
    checks++; if (oe2 !== 1'b1 || dout2 !== 8'hAC || cas_hi !== 0) begin
      errors++; $display("FAIL slave_match_data: oe=%b data=%h cas_hi=%0d, required 1/ac/0", oe2, dout2, cas_hi); end
    checks++; if (clr_cnt !== 1) begin errors++; $display("FAIL slave_match_clear: got %0d required 1", clr_cnt); end
    run_seq(1'b0, 1'b0, 1'b1, 8'h06, 3'd1, 3'd4, 5'b10101, 1'b0);
    checks++; if (set_cnt !== 0 || oe2 !== 1'b0 || oe_out !== 1'b0 || clr_cnt !== 0) begin
      errors++; $display("FAIL slave_mismatch: set=%0d oe=%b oe_other=%b clr=%0d, required 0/0/0/0", set_cnt, oe2, oe_out, clr_cnt); end
  endtask

  task automatic test_spurious();
    run_seq(1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 3'd2, 5'b00110, 1'b1);
    checks++; if (int_after !== 1'b0 || set_cnt !== 0) begin
      errors++; $display("FAIL spur_no_set: int_after=%b set=%0d, required 0/0", int_after, set_cnt); end
    checks++; if (oe2 !== 1'b1 || dout2 !== 8'h37) begin
      errors++; $display("FAIL spur_vector: oe=%b data=%h, required 1/37", oe2, dout2); end
    checks++; if (clr_cnt !== 0) begin errors++; $display("FAIL spur_no_clear: got %0d required 0", clr_cnt); end
  endtask

  task automatic test_timeout();
    int k = 0;
    single = 1'b0; sp = 1'b1; aeoi = 1'b1; icw3 = 8'hFF; vector_base = 5'd9;
    int_index = 3'($urandom); icw_done = 1'b1; inta_n = 1'b1;
    clear_capture();
    int_request = 1'b1;
    wait_int();
    step();
    inta_n = 1'b0; open_win(1); step();
    int_request = 1'b0;
    inta_n = 1'b1; step();
    while (to_cnt == 0 && k < 20) begin step(); k++; end
    checks++; if (k !== TO) begin errors++; $display("FAIL timeout_delay: %0d cycles, required %0d", k, TO); end
    checks++; if (freeze !== 1'b0 || cas_oe !== 1'b0 || intr !== 1'b0) begin
      errors++; $display("FAIL timeout_release: freeze=%b cas_oe=%b int=%b, required 0/0/0", freeze, cas_oe, intr); end
    repeat (3) step();
    checks++; if (to_cnt !== 1 || clr_cnt !== 0 || set_cnt !== 1) begin
      errors++; $display("FAIL timeout_pulses: abort=%0d clr=%0d set=%0d, required 1/0/1", to_cnt, clr_cnt, set_cnt); end
    int_request = 1'b1; step();
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL timeout_idle: int=%b required 1", intr); end
    pulse_reset();
  endtask

  task automatic test_early_fall();
    single = 1'b1; sp = 1'b1; aeoi = 1'b0; icw_done = 1'b1; int_index = 3'd6;
    clear_capture();
    int_request = 1'b1; inta_n = 1'b0; step(); step(); step();
    checks++; if (intr !== 1'b1 || set_cnt !== 0) begin
      errors++; $display("FAIL early_fall_ignored: int=%b set=%0d, required 1/0", intr, set_cnt); end
    inta_n = 1'b1; step(); inta_n = 1'b0; step();
    checks++; if (set_cnt !== 1 || isr_index !== 3'd6) begin
      errors++; $display("FAIL early_fall_next: set=%0d idx=%0d, required 1/6", set_cnt, isr_index); end
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    single = 1'b1; sp = 1'b1; aeoi = 1'b1; vector_base = 5'd3; icw_done = 1'b1;
    int_index = 3'($urandom); inta_n = 1'b1;
    clear_capture();
    int_request = 1'b1;
    wait_int();
    step();
    inta_n = 1'b0; step(); inta_n = 1'b1; step(); inta_n = 1'b0; step();
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL rstmid_pre: data_oe=%b required 1", data_oe); end
    reset = 1'b1; inta_n = 1'b1; int_request = 1'b0; open_win(3); clr_cnt = 0; step();
    checks++;
    if ({intr, freeze, isr_set, isr_index, isr_clear, data_out, data_oe, cas_out, cas_oe, timeout_abort} !== 21'd0) begin
      errors++; $display("FAIL rstmid_outputs: data_oe=%b freeze=%b data_out=%h, required all 0", data_oe, freeze, data_out); end
    reset = 1'b0; repeat (3) step();
    checks++; if (clr_cnt !== 0 || data_oe !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_clear: clr=%0d data_oe=%b, required 0/0", clr_cnt, data_oe); end
  endtask

  task automatic test_random();
    logic s, p, a, d, e_casc, e_set, e_drive, e_clr;
    logic [7:0] i3, e_vec;
    logic [2:0] ci, ix, e_idx;
    logic [4:0] vb;
    int e_set_w;
    for (int n = 0; n < 24; n++) begin
      s = 1'($urandom); p = 1'($urandom); a = 1'($urandom); d = ($urandom_range(0, 5) == 0);
      i3 = 8'($urandom); ix = 3'($urandom); vb = 5'($urandom);
      ci = ($urandom_range(0, 1) == 1) ? i3[2:0] : 3'($urandom);
      run_seq(s, p, a, i3, ci, ix, vb, d);
      model(s, p, a, i3, ci, ix, vb, d, e_idx, e_casc, e_set, e_set_w, e_drive, e_vec, e_clr);
      checks++; if (int_req_seen !== 1'b1 || int_after !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_int: req=%b after=%b, required 1/0", n, int_req_seen, int_after); end
      checks++; if (set_cnt !== (e_set ? 1 : 0) || (e_set && (set_idx !== e_idx || set_w !== e_set_w || set_pos !== 1))) begin
        errors++; $display("FAIL rnd%0d_set: cnt=%0d idx=%0d win=%0d, required %0d/%0d/%0d", n, set_cnt, set_idx, set_w, e_set, e_idx, e_set_w); end
      checks++; if (oe2 !== e_drive || (e_drive && dout2 !== e_vec) || oe_out !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_data: oe=%b data=%h other=%b, required %b/%h/0", n, oe2, dout2, oe_out, e_drive, e_vec); end
      checks++; if (e_casc ? (cas_lo !== 0 || cas_val !== e_idx) : (cas_hi !== 0)) begin
        errors++; $display("FAIL rnd%0d_cas: hi=%0d lo=%0d val=%0d, required casc=%b idx=%0d", n, cas_hi, cas_lo, cas_val, e_casc, e_idx); end
      checks++; if (frz1 !== 1'b1 || frz_end !== 1'b0 || to_cnt !== 0) begin
        errors++; $display("FAIL rnd%0d_freeze: ack1=%b end=%b abort=%0d, required 1/0/0", n, frz1, frz_end, to_cnt); end
      checks++; if (clr_cnt !== (e_clr ? 1 : 0) || (e_clr && (clr_idx !== e_idx || clr_pos !== 1))) begin
        errors++; $display("FAIL rnd%0d_clear: cnt=%0d idx=%0d pos=%0d, required %0d/%0d/1", n, clr_cnt, clr_idx, clr_pos, e_clr, e_idx); end
    end
  endtask

  initial begin
    reset = 1'b1; int_request = 1'b0; int_index = '0; inta_n = 1'b1; icw_done = 1'b0;
    vector_base = '0; aeoi = 1'b0; single = 1'b1; sp = 1'b1; icw3 = '0; cas_in = '0;
    clear_capture();
    test_reset();
    test_single_vector();
    test_aeoi();
    test_cascade_master();
    test_slave();
    test_spurious();
    test_timeout();
    test_early_fall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
